encoder: RTL and testbench
==========================

// Module: encoder
// PURPOSE
//   Registered 16-to-4 priority encoder. Converts a 16-bit request/one-hot vector
//   into the 4-bit index of its highest set bit, plus a valid flag.
//   Sits between request-generating logic and index-consuming logic (mux selects,
//   arbiter grants), where a registered, glitch-free index is required.
//   Exact one-hot encoder for one-hot inputs; defined priority for all other inputs.
// PARAMETERS
//   IN_W   16  input vector width; must be a power of two, >= 2
//   OUT_W  4   index width; must equal log2(IN_W); derived, do not override independently
// PORTS
//   clk    in   1      system clock; all state updates on rising edge
//   rst_n  in   1      asynchronous reset, active-low
//   in     in   IN_W   request vector; bit i set = request at index i
//   s_out  out  OUT_W  encoded index of the highest set bit of in (registered)
//   c_out  out  1      valid: 1 when in had at least one bit set (registered)
// BEHAVIOUR
//   - Single clock domain: clk. Reset rst_n is asynchronous assert, active-low.
//     Deassertion is synchronised by the system reset controller upstream.
//   - While rst_n=0, outputs are forced immediately, independent of clk:
//     s_out=0, c_out=0.
//   - Combinational stage: idx = highest i with in[i]=1; any = |in.
//   - Register stage: at each rising clk with rst_n=1: s_out<=idx, c_out<=any.
//   - Latency: exactly 1 clock from in to s_out/c_out. No handshake.
//     A new vector is accepted every cycle (throughput 1/cycle).
//   - One-hot input 1<<k (k=0..15): s_out=k, c_out=1.
//   - Multiple bits set: highest index wins; lower bits are ignored.
//     Example: 0x8001 -> 15; 0x0006 -> 2.
//   - All-zero input: s_out=0, c_out=0. s_out=0 with c_out=1 means only bit 0 was set.
//   - X/Z on in is not defined behaviour; the bench drives known values only.
//   - Reset asserted mid-stream: outputs clear at once. The first valid output after
//     release reflects in sampled at the first rising clk with rst_n=1.
//   - No other state exists; no FSM.
//   - Implementation: use a loop or casez priority. Do not use a chain of OR-reductions
//     that assumes one-hot input.
// TESTING
//   1. Reset: rst_n=0 with in=0xFFFF, clk running -> s_out=0, c_out=0 throughout;
//      release rst_n -> next edge gives s_out=15, c_out=1.
//   2. One-hot sweep: in=1<<k for k=0..15, one per cycle -> s_out=k, c_out=1,
//      one cycle after each apply.
//   3. Zero input: in=0x0000 -> s_out=0, c_out=0; then in=0x0001 -> s_out=0, c_out=1
//      (distinguishes the two cases).
//   4. Priority: in=0x8001 -> 15; in=0x0006 -> 2; in=0x0FF0 -> 11; in=0xFFFF -> 15;
//      all with c_out=1.
//   5. Async reset mid-run: assert rst_n between clock edges while in=0x0400 ->
//      s_out/c_out go to 0 before the next edge.
//   6. Back-to-back: change in on every cycle using a random vector ->
//      outputs equal a reference model delayed by exactly 1 cycle.

Source files
------------

// File: rtl/encoder.sv
// ---------------------------------------------------------------------------
// encoder
//   Registered priority encoder. Converts an IN_W-bit request vector into the
//   index of its highest set bit plus a valid flag, both registered so the
//   downstream mux selects / arbiter grants see a glitch-free index.
//   For one-hot inputs this is an exact one-hot encoder; for any other input
//   the highest set bit wins and lower bits are ignored.
//
// Parameters
//   IN_W   input vector width (power of two, >= 2)
//   OUT_W  index width, derived as log2(IN_W); leave at its default
//
// Ports
//   clk    in   1      system clock, all state updates on rising edge
//   rst_n  in   1      asynchronous reset, active-low
//   in     in   IN_W   request vector, bit i set = request at index i
//   s_out  out  OUT_W  index of highest set bit of in (registered, 1 cycle)
//   c_out  out  1      1 when in had at least one bit set (registered)
// ---------------------------------------------------------------------------
module encoder #(
   parameter int IN_W  = 16,
   parameter int OUT_W = $clog2(IN_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] s_out,
   output logic             c_out
);

   logic [OUT_W-1:0] idx;
   logic             any;

   // Priority search: walking upward and overwriting on every set bit means
   // the last hit, i.e. the highest set bit, is what remains in idx. This is
   // correct for arbitrary inputs, not only one-hot ones. An all-zero input
   // leaves idx at 0, which is told apart from "bit 0 set" by any.
   always_comb begin
      idx = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (in[i]) begin
            idx = OUT_W'(i);
         end
      end
   end

   assign any = |in;

   // Output register: one cycle of latency, a new vector every cycle.
   // Reset clears the outputs immediately, independent of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_out <= '0;
         c_out <= 1'b0;
      end else begin
         s_out <= idx;
         c_out <= any;
      end
   end

endmodule

// File: tb/tb_encoder.sv
// ---------------------------------------------------------------------------
// tb_encoder
//   Self-checking bench for encoder (IN_W=16). Inputs change on the falling
//   edge and outputs are sampled on the falling edge, half a period away from
//   the capturing rising edge. Directed vectors come from a table of
//   hand-computed expectations; reset and back-to-back traffic are handled by
//   short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_encoder;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in    = '0;
   logic [3:0]  s_out;
   logic        c_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [15:0] vec;
      logic [3:0]  exp_s;
      logic        exp_c;
   } vec_t;

   vec_t vectors[$];

   // 10 ns clock period
   always #5 clk = ~clk;

   encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .s_out (s_out),
      .c_out (c_out)
   );

   // Reference model for random traffic: scan downward from the top bit.
   function automatic logic [4:0] ref_enc(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) return {1'b1, 4'(i)};
      end
      return 5'b0;
   endfunction

   // Drive a new input vector at the next falling edge.
   task automatic applyStimulus(input logic [15:0] v);
      @(negedge clk);
      in = v;
   endtask

   // Compare the current outputs against the required values.
   task automatic checkOutput(input string name, input logic [3:0] exp_s, input logic exp_c);
      n_checks++;
      if (s_out !== exp_s || c_out !== exp_c) begin
         n_fail++;
         $display("[TB] FAIL %s: got s_out=%0d c_out=%0b, expected s_out=%0d c_out=%0b",
                  name, s_out, c_out, exp_s, exp_c);
      end
   endtask

   function automatic void addVector(input string name, input logic [15:0] vec,
                                     input logic [3:0] exp_s, input logic exp_c);
      vec_t v;
      v.name  = name;
      v.vec   = vec;
      v.exp_s = exp_s;
      v.exp_c = exp_c;
      vectors.push_back(v);
   endfunction

   initial begin
      logic [15:0] rv;
      logic [4:0]  prev_exp;

      // Directed table: one-hot sweep, zero vs bit 0, priority cases.
      for (int k = 0; k < 16; k++) begin
         addVector($sformatf("onehot_%0d", k), 16'h0001 << k, 4'(k), 1'b1);
      end
      addVector("zero",        16'h0000, 4'd0,  1'b0);
      addVector("bit0_only",   16'h0001, 4'd0,  1'b1);
      addVector("prio_8001",   16'h8001, 4'd15, 1'b1);
      addVector("prio_0006",   16'h0006, 4'd2,  1'b1);
      addVector("prio_0ff0",   16'h0FF0, 4'd11, 1'b1);
      addVector("prio_ffff",   16'hFFFF, 4'd15, 1'b1);
      addVector("zero_again",  16'h0000, 4'd0,  1'b0);
      addVector("prio_0300",   16'h0300, 4'd9,  1'b1);

      // Reset held with all requests active: outputs must stay cleared.
      rst_n = 1'b0;
      in    = 16'hFFFF;
      #1;
      checkOutput("reset_initial", 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset_hold", 4'd0, 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_release", 4'd15, 1'b1);

      // Table vectors back-to-back; each result is checked one cycle later.
      for (int i = 0; i < vectors.size(); i++) begin
         @(negedge clk);
         if (i > 0) checkOutput(vectors[i-1].name, vectors[i-1].exp_s, vectors[i-1].exp_c);
         in = vectors[i].vec;
      end
      @(negedge clk);
      checkOutput(vectors[vectors.size()-1].name,
                  vectors[vectors.size()-1].exp_s, vectors[vectors.size()-1].exp_c);

      // Asynchronous reset between clock edges.
      applyStimulus(16'h0400);
      @(negedge clk);
      checkOutput("pre_async", 4'd10, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_clear", 4'd0, 1'b0);
      @(negedge clk);
      checkOutput("async_hold", 4'd0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_after_release", 4'd10, 1'b1);

      // Random back-to-back traffic against the model, 1-cycle delay.
      prev_exp = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i > 0) checkOutput($sformatf("random_%0d", i-1), prev_exp[3:0], prev_exp[4]);
         rv = 16'($urandom);
         if (i % 8 == 3) rv = 16'h0000;
         if (i % 8 == 5) rv = rv & 16'h00FF;
         in       = rv;
         prev_exp = ref_enc(rv);
      end
      @(negedge clk);
      checkOutput("random_39", prev_exp[3:0], prev_exp[4]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
